// File: rtl/i2s_tx.sv
// I2S master transmitter: divides clk_in into sck/ws and serialises stereo pairs MSB-first.
// Optional I2S_TX_HOLD_LAST_EN: on underrun, repeat the last transmitted pair instead of zeros.
module i2s_tx #(
   parameter int SCALER = 10,
   parameter int DATA_W = 24,
   parameter int SLOT_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              tx_en,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] left_data,
   input  logic [DATA_W-1:0] right_data,
   output logic              sck,
   output logic              ws,
   output logic              sd,
   output logic              busy,
   output logic              underrun
);

   localparam int HALF    = SCALER / 2;
   localparam int FRAME_W = 2 * SLOT_W;
   localparam int HC_W    = (HALF > 2) ? $clog2(HALF) : 1;
   localparam int B_W     = $clog2(FRAME_W);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_reg;
   logic [HC_W-1:0]    hc_reg;
   logic [B_W-1:0]     b_reg;
   logic [B_W-1:0]     b_next;
   logic [FRAME_W-1:0] hold_reg;
   logic [FRAME_W-1:0] shift_reg;
   logic [FRAME_W-1:0] in_frame;
   logic               hold_full_reg;
   logic               sck_reg;
   logic               ws_reg;
   logic               sd_reg;
   logic               busy_reg;
   logic               underrun_reg;
   logic               half_done;
   logic               wrap;
   logic               ws_next;
`ifdef I2S_TX_HOLD_LAST_EN
   logic [FRAME_W-1:0] last_reg;
`endif

   // Whole frame image: each sample left-aligned in its slot, zero padded below.
   assign in_frame  = (FRAME_W'(left_data) << (FRAME_W - DATA_W))
                    | (FRAME_W'(right_data) << (SLOT_W - DATA_W));

   assign half_done = (hc_reg == HC_W'(HALF - 1));
   assign wrap      = (b_reg == B_W'(FRAME_W - 1));
   assign b_next    = wrap ? '0 : b_reg + B_W'(1);
   // ws is high for bits SLOT_W-1 .. FRAME_W-2, leading each MSB by one bit
   assign ws_next   = (b_next >= B_W'(SLOT_W - 1)) && (b_next != B_W'(FRAME_W - 1));

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         hc_reg        <= '0;
         b_reg         <= '0;
         hold_reg      <= '0;
         shift_reg     <= '0;
         hold_full_reg <= 1'b0;
         sck_reg       <= 1'b0;
         ws_reg        <= 1'b0;
         sd_reg        <= 1'b0;
         busy_reg      <= 1'b0;
         underrun_reg  <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
         last_reg      <= '0;
`endif
      end else begin
         underrun_reg <= 1'b0;
         if (s_valid && !hold_full_reg) begin
            hold_full_reg <= 1'b1;
            hold_reg      <= in_frame;
         end
         case (state_reg)
            IDLE: begin
               if (tx_en) begin
                  state_reg <= RUN;
                  b_reg     <= B_W'(FRAME_W - 1);
                  hc_reg    <= '0;
                  sck_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
               end
            end
            RUN: begin
               if (!half_done) begin
                  hc_reg <= hc_reg + HC_W'(1);
               end else begin
                  hc_reg  <= '0;
                  sck_reg <= ~sck_reg;
                  if (sck_reg) begin
                     if (wrap && !tx_en) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        sck_reg   <= 1'b0;
                        ws_reg    <= 1'b0;
                        sd_reg    <= 1'b0;
                        b_reg     <= '0;
                     end else begin
                        b_reg  <= b_next;
                        ws_reg <= ws_next;
                        if (!wrap) begin
                           sd_reg    <= shift_reg[FRAME_W-1];
                           shift_reg <= shift_reg << 1;
                        end else if (hold_full_reg) begin
                           sd_reg        <= hold_reg[FRAME_W-1];
                           shift_reg     <= hold_reg << 1;
                           hold_full_reg <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
                           last_reg      <= hold_reg;
`endif
                        end else begin
                           underrun_reg <= 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                           sd_reg       <= last_reg[FRAME_W-1];
                           shift_reg    <= last_reg << 1;
`else
                           sd_reg       <= 1'b0;
                           shift_reg    <= '0;
`endif
                        end
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign s_ready  = !hold_full_reg;
   assign sck      = sck_reg;
   assign ws       = ws_reg;
   assign sd       = sd_reg;
   assign busy     = busy_reg;
   assign underrun = underrun_reg;

endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S master transmitter, the playback-side counterpart of the capture path. It divides `clk_in` to generate the bit clock `sck` and the word select `ws`. It accepts stereo sample pairs over a valid/ready handshake and serialises them MSB-first in standard I2S format, with a one-`sck` delay after each `ws` transition. It drives codecs and DACs, and serves as a stimulus source for loop-back testing of the I2S capture logic.

## Interface
- `SCALER`, default 10: `clk_in` cycles per `sck` period. Must be even and ≥4.
- `DATA_W`, default 24: sample width in bits, left-aligned in the slot.
- `SLOT_W`, default 32: `sck` periods per channel slot. Must be ≥ `DATA_W` and ≤ 64.
- `clk_in`, input, 1: system clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tx_en`, input, 1: run request.
- `s_valid`, input, 1: sample pair valid.
- `s_ready`, output, 1: holding register empty.
- `left_data`, input, `DATA_W`: left sample, two's complement.
- `right_data`, input, `DATA_W`: right sample.
- `sck`, output, 1: I2S bit clock, 50 % duty.
- `ws`, output, 1: word select; 0 = left, 1 = right.
- `sd`, output, 1: serial data.
- `busy`, output, 1: transmitter running.
- `underrun`, output, 1: one-cycle pulse when a frame starts with no sample available.

## Operation
**Reset values**
- `sck`, `ws`, `sd`, `busy`, `underrun` = 0.
- Holding register is empty, so `s_ready` = 1.

**Handshake**
- Transfer occurs when `s_valid && s_ready` on a `clk_in` edge.
- The pair is stored in a one-entry holding register.
- `s_ready` = !hold_full and is independent of `tx_en`.

**Clock generation**
- Half-period counter `hc` counts 0..SCALER/2-1.
- `sck` toggles when `hc` == SCALER/2-1.
- While idle: `hc` = 0 and `sck` = 0.

**Bit index**
- Bit index `b` runs 0..2·SLOT_W-1 and advances on every `sck` falling edge.
- When `b` wraps to 0, a new frame starts.

**Frame start**
- If the holding register is full: its contents load into the shift register and the holding register empties.
- If it is empty: the shift register loads zeros and `underrun` pulses for one cycle.

**Slot contents**
- `sd` = slot bit `b` mod SLOT_W, MSB first.
- Bits 0..DATA_W-1 of the slot are sample bits; the remaining bits are 0.
- Slots with b < SLOT_W carry left; slots with b ≥ SLOT_W carry right.

**Word select**
- `ws` = 1 for b ∈ [SLOT_W-1, 2·SLOT_W-2]; otherwise `ws` = 0.
- `ws` therefore changes one bit before each MSB.

**State machine**
- IDLE → RUN when `tx_en` = 1. On entry: `b` = 2·SLOT_W-1, `hc` = 0, `sck` = 0, `busy` = 1.
- RUN → IDLE at the `sck` falling edge that would wrap `b` to 0 while `tx_en` = 0. The current frame always completes.
- On entering IDLE, `busy`, `sck`, `ws` and `sd` return to 0 in that same cycle.
- Deasserting `tx_en` and reasserting it before the frame ends has no effect; transmission continues seamlessly.
- Asserting `rst_n` mid-frame aborts immediately. All outputs take their reset values and the holding register is emptied.

## Timing
- `sck`, `ws`, `sd` are registered and change in the same `clk_in` cycle as the `sck` falling edge. `sd` and `ws` are never updated on a rising edge.
- First `sck` rising edge: SCALER/2 cycles after the cycle in which `tx_en` is sampled high.
- First MSB driven: SCALER cycles after `tx_en` is sampled high, at the first falling edge.
- `s_ready` timing:
  - Falls the cycle after acceptance.
  - Rises the cycle after the frame-start load.
  - There is no same-cycle bypass: a pair offered in the load cycle is not accepted until the next cycle.
- `underrun` is asserted in the same cycle as the frame-start falling edge.
- Frame period = 2·SLOT_W·SCALER `clk_in` cycles.

## Configuration
- Macro: `I2S_TX_HOLD_LAST_EN`.
- Defined: on underrun, the shift register reloads the last transmitted pair (zeros if none since reset). `underrun` still pulses.
- Undefined: on underrun, zeros are transmitted.

## Test plan
Parameters for all scenarios: SCALER=4, DATA_W=24, SLOT_W=32.

- **Reset:** hold `rst_n` = 0 with `tx_en` = 1 → `sck`/`ws`/`sd`/`busy`/`underrun` = 0, `s_ready` = 1. Release → first `sck` rise 2 cycles after `tx_en` is sampled.
- **Single frame:** push L=0xA5A5A5, R=0x5A5A5A before `tx_en` →
  - Left slot: 1010_0101… followed by 8 zeros, with `ws` = 0.
  - `ws` rises at b=31; right slot follows.
  - Frame length is 256 `clk_in` cycles.
  - `underrun` = 0.
- **Back-to-back streaming:** push pairs with `s_valid` held high continuously for 4 frames → each frame carries the next pair, with no gaps and no `underrun`. `s_ready` rises exactly 1 cycle after each load.
- **Underrun:** no second pair is supplied → at the second frame start `underrun` pulses for exactly 1 cycle.
  - Without the macro: `sd` = 0 for the whole frame.
  - With `I2S_TX_HOLD_LAST_EN`: 0xA5A5A5/0x5A5A5A repeats.
- **Stop:** deassert `tx_en` at b=10 → the frame completes through b=63; `busy` falls at the wrap edge; `sck` stays 0 afterwards. A toggle of `tx_en` 1→0→1 within a frame causes no interruption.
- **Reset mid-frame:** assert `rst_n` = 0 at b=40 with the holding register full → outputs are 0 immediately and `s_ready` = 1. On restart, zeros are transmitted and `underrun` pulses.
